// File: rtl/tap_byte_driver_pkg.sv
// Shared types for the TAP byte driver: FSM states, strobe bundle, width defaults.
package tap_byte_driver_pkg;

  localparam int TAP_DATA_WIDTH   = 8;
  localparam int TAP_RESULT_WIDTH = 16;

  typedef enum logic [3:0] {
    TLR, IDLE, CAPTURE, SHIFT, UPDATE, GAP, RB_CAPTURE, RB_SHIFT, RB_UPDATE, DONE
  } tap_state_e;

  typedef struct packed {
    logic tdi;
    logic tlr;
    logic rti;
    logic ir_user;
    logic capture;
    logic shift;
    logic update;
  } tap_strb_t;

  // One strobe per state, so exclusivity holds by construction.
  function automatic tap_strb_t strb_of(tap_state_e s, logic tdi, logic ir_user);
    tap_strb_t t;
    t         = '0;
    t.tdi     = tdi;
    t.ir_user = ir_user;
    t.tlr     = (s == TLR);
    t.rti     = (s == IDLE) || (s == GAP) || (s == DONE);
    t.capture = (s == CAPTURE) || (s == RB_CAPTURE);
    t.shift   = (s == SHIFT) || (s == RB_SHIFT);
    t.update  = (s == UPDATE) || (s == RB_UPDATE);
    return t;
  endfunction

endpackage

// File: rtl/tap_scan_shifter.sv
// Right-shifting scan register with bit counter; serial out at bit 0, serial in at the MSB.
module tap_scan_shifter #(
  parameter int W  = 16,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [W-1:0]  i_data,
  input  logic          i_shift,
  input  logic          i_sin,
  output logic          o_sout,
  output logic [W-1:0]  o_par,
  output logic [CW-1:0] o_cnt
);

  logic [W-1:0]  r_sr;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= i_data;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sr  <= {i_sin, r_sr[W-1:1]};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sout = r_sr[0];
  assign o_par  = r_sr;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/tap_byte_driver.sv
// Drives TAP DR scans from a byte stream, then reads back a result word over tdo.
// Optional TAP_BYTE_DRIVER_POLL_EN: rescan a zero result every POLL_INTERVAL idle cycles.
module tap_byte_driver
  import tap_byte_driver_pkg::*;
#(
  parameter int DATA_WIDTH    = TAP_DATA_WIDTH,
  parameter int RESULT_WIDTH  = TAP_RESULT_WIDTH,
  parameter int RESET_CYCLES  = 5,
  parameter int GAP_CYCLES    = 2,
  parameter int POLL_INTERVAL = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_last,
  input  logic                    readback_req,
  output logic                    tap_tdi,
  input  logic                    tap_tdo,
  output logic                    tap_test_logic_reset,
  output logic                    tap_run_test_idle,
  output logic                    tap_ir_is_user,
  output logic                    tap_capture_dr,
  output logic                    tap_shift_dr,
  output logic                    tap_update_dr,
  output logic                    result_valid,
  output logic [RESULT_WIDTH-1:0] result_data,
  output logic                    busy
);

  localparam int CW = $clog2(RESULT_WIDTH + 1);
  localparam int TW = 16;

  tap_state_e              r_state, w_nxt;
  tap_strb_t               r_strb;
  logic [TW-1:0]           r_tim;
  logic                    r_in_ready, r_busy, r_rv;
  logic [RESULT_WIDTH-1:0] r_rd;
  logic                    r_last_seen, r_rb_pend, r_poll;
  logic                    w_acc, w_req, w_load, w_shift, w_sout;
  logic [RESULT_WIDTH-1:0] w_par;
  logic [CW-1:0]           w_cnt;

  assign w_acc = in_valid & r_in_ready;
`ifdef TAP_BYTE_DRIVER_POLL_EN
  assign w_req = readback_req & 1'b0;
`else
  assign w_req = readback_req;
`endif

  // Bytes load on acceptance; readback clears the register on entry to RB_CAPTURE.
  assign w_load  = w_acc | (w_nxt == RB_CAPTURE);
  assign w_shift = (w_nxt == SHIFT) | (r_state == RB_SHIFT && !rst);

  tap_scan_shifter #(.W(RESULT_WIDTH), .CW(CW)) u_shifter (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_load),
    .i_data (w_acc ? RESULT_WIDTH'(in_data) : '0),
    .i_shift(w_shift),
    .i_sin  (tap_tdo),
    .o_sout (w_sout),
    .o_par  (w_par),
    .o_cnt  (w_cnt)
  );

  always_comb begin
    w_nxt = r_state;
    if (rst) w_nxt = TLR;
    else begin
      case (r_state)
        TLR:        if (r_tim == TW'(RESET_CYCLES - 1)) w_nxt = IDLE;
        IDLE:       if (w_acc) w_nxt = CAPTURE;
                    else if (w_req) w_nxt = RB_CAPTURE;
        CAPTURE:    w_nxt = SHIFT;
        SHIFT:      if (w_cnt == CW'(DATA_WIDTH)) w_nxt = UPDATE;
        UPDATE:     w_nxt = GAP;
        GAP:        if (r_tim == TW'(GAP_CYCLES - 1))
                      w_nxt = (r_last_seen || r_rb_pend) ? RB_CAPTURE : IDLE;
        RB_CAPTURE: w_nxt = RB_SHIFT;
        RB_SHIFT:   if (w_cnt == CW'(RESULT_WIDTH - 1)) w_nxt = RB_UPDATE;
        RB_UPDATE:  w_nxt = r_last_seen ? DONE : IDLE;
        DONE:       if (r_poll && r_tim == TW'(POLL_INTERVAL - 1)) w_nxt = RB_CAPTURE;
                    else if (w_req) w_nxt = RB_CAPTURE;
        default:    w_nxt = TLR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= TLR;
      r_tim       <= '0;
      r_strb      <= strb_of(TLR, 1'b0, 1'b0);
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_rv        <= 1'b0;
      r_rd        <= '0;
      r_last_seen <= 1'b0;
      r_rb_pend   <= 1'b0;
      r_poll      <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_tim      <= (w_nxt == r_state) ? r_tim + 1'b1 : '0;
      r_strb     <= strb_of(w_nxt, (w_nxt == SHIFT) ? w_sout : 1'b0,
                            r_strb.ir_user | (r_state == TLR && w_nxt != TLR));
      r_in_ready <= (w_nxt == IDLE);
      // TLR is not a scan, so busy stays low there as it does in reset.
      r_busy     <= !(w_nxt inside {TLR, IDLE, DONE});
      r_rv       <= 1'b0;
      if (w_acc && in_last) r_last_seen <= 1'b1;
      if (w_nxt == RB_CAPTURE) r_rb_pend <= 1'b0;
      else if (w_req && (w_nxt inside {CAPTURE, SHIFT, UPDATE, GAP})) r_rb_pend <= 1'b1;
      if (r_state == RB_UPDATE) begin
`ifdef TAP_BYTE_DRIVER_POLL_EN
        if (r_last_seen && w_par == '0) r_poll <= 1'b1;
        else begin
          r_poll <= 1'b0;
          r_rd   <= w_par;
          r_rv   <= 1'b1;
        end
`else
        r_rd <= w_par;
        r_rv <= 1'b1;
`endif
      end
    end
  end

  assign in_ready             = r_in_ready;
  assign tap_tdi              = r_strb.tdi;
  assign tap_test_logic_reset = r_strb.tlr;
  assign tap_run_test_idle    = r_strb.rti;
  assign tap_ir_is_user       = r_strb.ir_user;
  assign tap_capture_dr       = r_strb.capture;
  assign tap_shift_dr         = r_strb.shift;
  assign tap_update_dr        = r_strb.update;
  assign result_valid         = r_rv;
  assign result_data          = r_rd;
  assign busy                 = r_busy;

endmodule

// File: tb/tb_tap_byte_driver.sv
// Directed bench for tap_byte_driver with a small tdo responder and strobe monitor.
module tb_tap_byte_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, readback_req = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, tap_tdi, tap_tdo = 1'b0;
  logic        tap_test_logic_reset, tap_run_test_idle, tap_ir_is_user;
  logic        tap_capture_dr, tap_shift_dr, tap_update_dr;
  logic        result_valid, busy;
  logic [15:0] result_data;

  int n_chk = 0, n_fail = 0;
  int bidx = 0, rb_idx = 0, n_upd = 0, n_rb = 0, n_rv = 0, cyc = 0;
  int t_rbu = -1, min_gap = 100000;
  logic [15:0] tb_sr = '0, last_rd = '0;
  logic [7:0]  last_byte = '0;
  logic [15:0] rb_ans [3];
  logic [7:0]  got_q [$];

  tap_byte_driver dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .readback_req(readback_req), .tap_tdi(tap_tdi), .tap_tdo(tap_tdo),
    .tap_test_logic_reset(tap_test_logic_reset), .tap_run_test_idle(tap_run_test_idle),
    .tap_ir_is_user(tap_ir_is_user), .tap_capture_dr(tap_capture_dr),
    .tap_shift_dr(tap_shift_dr), .tap_update_dr(tap_update_dr),
    .result_valid(result_valid), .result_data(result_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Responder: presents the queued answer on tdo, records tdi of each scan.
  always @(negedge clk) begin
    cyc++;
    if (tap_capture_dr) begin
      if (t_rbu >= 0 && cyc - t_rbu - 1 < min_gap) min_gap = cyc - t_rbu - 1;
      bidx  = 0;
      tb_sr = '0;
    end else if (tap_shift_dr) begin
      tb_sr[bidx[3:0]] = tap_tdi;
      tap_tdo = rb_ans[rb_idx][bidx[3:0]];
      bidx++;
    end else if (tap_update_dr) begin
      n_upd++;
      if (bidx == 16) begin
        n_rb++;
        t_rbu = cyc;
        if (rb_idx < 2) rb_idx++;
      end else begin
        last_byte = tb_sr[7:0];
        got_q.push_back(tb_sr[7:0]);
      end
    end
    if (result_valid) begin
      n_rv++;
      last_rd = result_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int n = 0;
    while (!in_ready && n < 300) begin tick(); n++; end
    if (n >= 300) chk("ready_timeout", 0, 1);
    in_valid = 1'b1; in_data = d; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic reset_and_count_tlr(input string tag);
    int n = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    while (tap_test_logic_reset && n < 20) begin n++; tick(); end
    chk(tag, n, 5);
  endtask

  initial begin
    logic [7:0]  exp_a5 [8];
    logic [7:0]  str [9];
    int n, base_upd, base_rb, base_rv;
    exp_a5 = '{1, 0, 1, 0, 0, 1, 0, 1};
    str    = '{8'h61, 8'h61, 8'h61, 8'h3A, 8'h20, 8'h79, 8'h6F, 8'h75, 8'h0A};
    rb_ans = '{16'h0000, 16'h0000, 16'h0000};

    // Reset values and TLR length
    repeat (3) tick();
    chk("rst_tlr", tap_test_logic_reset, 1);
    chk("rst_rti", tap_run_test_idle, 0);
    chk("rst_ir", tap_ir_is_user, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_rd", result_data, 0);
    reset_and_count_tlr("tlr_len");
    chk("idle_rti", tap_run_test_idle, 1);
    chk("idle_ir", tap_ir_is_user, 1);
    chk("idle_ready", in_ready, 1);

    // Single byte 0xA5
    send(8'hA5, 1'b0);
    chk("a5_capture", tap_capture_dr, 1);
    chk("a5_busy", busy, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("a5_shift", tap_shift_dr, 1);
      chk("a5_tdi", tap_tdi, exp_a5[k][0]);
    end
    tick(); chk("a5_update", tap_update_dr, 1);
    tick(); chk("a5_gap1", {tap_run_test_idle, in_ready}, 2'b10);
    tick(); chk("a5_gap2", {tap_run_test_idle, in_ready}, 2'b10);
    tick(); chk("a5_ready12", in_ready, 1);
    chk("a5_seen", last_byte, 8'hA5);

    // Byte and readback_req in the same IDLE cycle
    rb_ans = '{16'hBEEF, 16'hBEEF, 16'hBEEF}; rb_idx = 0;
    base_rb = n_rb; base_rv = n_rv;
    in_valid = 1'b1; in_data = 8'h5A; readback_req = 1'b1;
    tick();
    in_valid = 1'b0; readback_req = 1'b0;
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    chk("both_latency", n, 30);
    chk("both_rv", result_valid, 1);
    chk("both_rd", result_data, 16'hBEEF);
    repeat (20) tick();
    chk("both_byte", last_byte, 8'h5A);
    chk("both_one_rb", n_rb - base_rb, 1);
    chk("both_one_rv", n_rv - base_rv, 1);
    chk("both_idle", in_ready, 1);

    // Reset in the middle of shifting 0x3C
    base_upd = n_upd;
    send(8'h3C, 1'b0);
    tick(); chk("abort_tdi0", tap_tdi, 0);
    tick(); chk("abort_tdi1", tap_tdi, 0);
    tick(); chk("abort_tdi2", tap_tdi, 1);
    tick(); chk("abort_tdi3", tap_tdi, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_strobes", {tap_capture_dr, tap_shift_dr, tap_update_dr, tap_run_test_idle}, 0);
    n = 0;
    while (tap_test_logic_reset && n < 20) begin n++; tick(); end
    chk("abort_tlr_len", n, 5);
    chk("abort_no_update", n_upd - base_upd, 0);
    chk("abort_ready", in_ready, 1);

    // Loopback-style stream "aaa: you\n", answer 0x0005
    rb_ans = '{16'h0005, 16'h0005, 16'h0005}; rb_idx = 0;
    got_q.delete();
    base_rv = n_rv;
    for (int i = 0; i < 9; i++) send(str[i], i == 8);
    n = 0;
    while (n_rv == base_rv && n < 400) begin tick(); n++; end
    tick();
    chk("lb_rv_once", n_rv - base_rv, 1);
    chk("lb_rd", last_rd, 16'h0005);
    chk("lb_nbytes", got_q.size(), 9);
    for (int i = 0; i < 9; i++) chk("lb_byte", (i < got_q.size()) ? got_q[i] : 8'hxx, str[i]);
    chk("lb_done", {in_ready, tap_run_test_idle, busy}, 3'b010);

    // Zero result after last byte: poll build rescans, default build reports zero
    reset_and_count_tlr("poll_tlr_len");
    rb_ans = '{16'h0000, 16'h0000, 16'h0123}; rb_idx = 0;
    base_rb = n_rb; base_rv = n_rv; t_rbu = -1; min_gap = 100000;
    send(8'h11, 1'b1);
    n = 0;
    while (n_rv == base_rv && n < 1000) begin tick(); n++; end
    repeat (150) tick();
`ifdef TAP_BYTE_DRIVER_POLL_EN
    chk("poll_scans", n_rb - base_rb, 3);
    chk("poll_rd", last_rd, 16'h0123);
    chk("poll_gap_ge64", min_gap >= 64, 1);
`else
    chk("single_scan", n_rb - base_rb, 1);
    chk("single_rd", last_rd, 16'h0000);
`endif
    chk("poll_rv_once", n_rv - base_rv, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
